// File: rtl/usb_data_fifo_pkg.sv
// Shared types for the USB/AHB byte FIFO: transfer-size encoding and its byte count.
package usb_data_fifo_pkg;

    typedef enum logic [1:0] {XFER_NONE, XFER_1B, XFER_2B, XFER_4B} xfer_size_t;

    localparam int LANES = 4;

    function automatic logic [2:0] xfer_bytes(input xfer_size_t size);
        case (size)
            XFER_1B: return 3'd1;
            XFER_2B: return 3'd2;
            XFER_4B: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/usb_data_fifo_byte_array.sv
// DEPTH x 8 register file with four indexed write lanes and four read lanes at ptr+i.
module fifo_byte_array
    import usb_data_fifo_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic [LANES-1:0]           wr_en,
    input  logic [LANES-1:0][AW-1:0]   wr_idx,
    input  logic [LANES-1:0][7:0]      wr_byte,
    input  logic [AW-1:0]              rd_ptr,
    output logic [LANES-1:0][7:0]      rd_byte
);

    logic [7:0] mem [DEPTH];

    // Storage is never reset; occupancy masking hides stale contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) begin
                mem[wr_idx[i]] <= wr_byte[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            rd_byte[i] = mem[rd_ptr + AW'(i)];
        end
    end

endmodule

// File: rtl/usb_data_fifo.sv
// Byte-wide circular buffer between the AHB slave (1/2/4-byte access) and the USB
// packet engines (1 byte); holds pointers, occupancy, arbitration, clamping and flags.
module usb_data_fifo
    import usb_data_fifo_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  store_tx_data,
    input  logic [31:0] tx_data,
    input  logic [1:0]  get_rx_data,
    output logic [31:0] rx_data,
    input  logic        store_rx_packet_data,
    input  logic [7:0]  rx_packet_data,
    input  logic        get_tx_packet_data,
    output logic [7:0]  tx_packet_data,
    input  logic        clear,
    output logic [7:0]  buffer_occupancy,
    output logic        overflow,
    output logic        underflow,
    output logic        conflict
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]             rptr;
    logic [AW-1:0]             wptr;
    logic                      ahb_push;
    logic                      ahb_pop;
    logic [2:0]                push_req;
    logic [2:0]                pop_req;
    logic [2:0]                push_cnt;
    logic [2:0]                pop_cnt;
    logic [8:0]                occ_ext;
    logic [8:0]                space;
    logic                      over_req;
    logic                      under_req;
    logic                      both_active;
    logic [LANES-1:0]          wr_en;
    logic [LANES-1:0][AW-1:0]  wr_idx;
    logic [LANES-1:0][7:0]     wr_byte;
    logic [LANES-1:0][7:0]     peek;

    fifo_byte_array #(.DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_byte (wr_byte),
        .rd_ptr  (rptr),
        .rd_byte (peek)
    );

    // AHB side always wins arbitration; the USB side is only seen when AHB is idle.
    always_comb begin
        ahb_push    = (store_tx_data != XFER_NONE);
        ahb_pop     = (get_rx_data != XFER_NONE);
        push_req    = ahb_push ? xfer_bytes(xfer_size_t'(store_tx_data))
                               : {2'b00, store_rx_packet_data};
        pop_req     = ahb_pop ? xfer_bytes(xfer_size_t'(get_rx_data))
                              : {2'b00, get_tx_packet_data};
        both_active = (ahb_push && store_rx_packet_data) || (ahb_pop && get_tx_packet_data);

        occ_ext   = {1'b0, buffer_occupancy};
        under_req = (9'(pop_req) > occ_ext);
        pop_cnt   = under_req ? occ_ext[2:0] : pop_req;

        // Bytes popped this cycle free room for this cycle's push.
        space     = 9'(DEPTH) - occ_ext + 9'(pop_cnt);
        over_req  = (9'(push_req) > space);
        push_cnt  = over_req ? space[2:0] : push_req;
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            wr_en[i]   = !clear && (3'(i) < push_cnt);
            wr_idx[i]  = wptr + AW'(i);
            wr_byte[i] = ahb_push ? tx_data[8*i +: 8] : ((i == 0) ? rx_packet_data : 8'h00);
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            rx_data[8*i +: 8] = (8'(i) < buffer_occupancy) ? peek[i] : 8'h00;
        end
        tx_packet_data = (buffer_occupancy != 8'd0) ? peek[0] : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr             <= '0;
            wptr             <= '0;
            buffer_occupancy <= 8'd0;
            overflow         <= 1'b0;
            underflow        <= 1'b0;
            conflict         <= 1'b0;
        end else if (clear) begin
            rptr             <= '0;
            wptr             <= '0;
            buffer_occupancy <= 8'd0;
            overflow         <= 1'b0;
            underflow        <= 1'b0;
            conflict         <= 1'b0;
        end else begin
            wptr             <= wptr + AW'(push_cnt);
            rptr             <= rptr + AW'(pop_cnt);
            buffer_occupancy <= buffer_occupancy + 8'(push_cnt) - 8'(pop_cnt);
            overflow         <= over_req;
            underflow        <= under_req;
            conflict         <= both_active;
        end
    end

endmodule

// File: tb/tb_usb_data_fifo.sv
// Bench for usb_data_fifo: a vector table for the directed cases plus a byte-queue scoreboard.
module tb_usb_data_fifo;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  store_tx_data;
    logic [31:0] tx_data;
    logic [1:0]  get_rx_data;
    logic [31:0] rx_data;
    logic        store_rx_packet_data;
    logic [7:0]  rx_packet_data;
    logic        get_tx_packet_data;
    logic [7:0]  tx_packet_data;
    logic        clear;
    logic [7:0]  buffer_occupancy;
    logic        overflow;
    logic        underflow;
    logic        conflict;

    int passed = 0;
    int total  = 0;
    logic [7:0] sb [$];

    typedef struct {
        logic [1:0]  ps;
        logic [31:0] td;
        logic [1:0]  gs;
        logic        up;
        logic [7:0]  ub;
        logic        ug;
        logic        cl;
        logic        chk;
        logic [31:0] e_rx;
        logic [7:0]  e_tx;
        logic [7:0]  e_occ;
        logic [2:0]  e_flg;
    } vec_t;

    usb_data_fifo #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .clear                (clear),
        .buffer_occupancy     (buffer_occupancy),
        .overflow             (overflow),
        .underflow            (underflow),
        .conflict             (conflict)
    );

    always #5 clk = ~clk;

    function automatic int nbytes(input logic [1:0] s);
        case (s)
            2'd1: return 1;
            2'd2: return 2;
            2'd3: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic vec_t mkt(input logic [1:0] ps, input logic [31:0] td, input logic [1:0] gs,
                                 input logic up, input logic [7:0] ub, input logic ug, input logic cl,
                                 input logic [31:0] e_rx, input logic [7:0] e_tx,
                                 input logic [7:0] e_occ, input logic [2:0] e_flg);
        vec_t v;
        v.ps = ps; v.td = td; v.gs = gs; v.up = up; v.ub = ub; v.ug = ug; v.cl = cl;
        v.chk = 1'b1; v.e_rx = e_rx; v.e_tx = e_tx; v.e_occ = e_occ; v.e_flg = e_flg;
        return v;
    endfunction

    function automatic vec_t mkv(input logic [1:0] ps, input logic [31:0] td, input logic [1:0] gs,
                                 input logic up, input logic [7:0] ub, input logic ug, input logic cl);
        vec_t v;
        v = mkt(ps, td, gs, up, ub, ug, cl, 32'h0, 8'h0, 8'h0, 3'b000);
        v.chk = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        store_tx_data = 2'd0; tx_data = 32'h0; get_rx_data = 2'd0;
        store_rx_packet_data = 1'b0; rx_packet_data = 8'h0; get_tx_packet_data = 1'b0; clear = 1'b0;
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic cycle(input vec_t v);
        int preq, wreq, npop, nw, space, occ_before;
        logic [7:0] b;
        logic e_ovf, e_unf, e_conf;
        store_tx_data = v.ps; tx_data = v.td; get_rx_data = v.gs;
        store_rx_packet_data = v.up; rx_packet_data = v.ub; get_tx_packet_data = v.ug; clear = v.cl;
        #1;
        if (v.chk) begin
            check("tab_rx_data", rx_data, v.e_rx);
            check("tab_tx_packet_data", {24'h0, tx_packet_data}, {24'h0, v.e_tx});
        end
        preq = (v.gs != 2'd0) ? nbytes(v.gs) : int'(v.ug);
        wreq = (v.ps != 2'd0) ? nbytes(v.ps) : int'(v.up);
        e_ovf = 1'b0; e_unf = 1'b0; e_conf = 1'b0;
        if (v.cl) begin
            sb.delete();
        end else begin
            occ_before = sb.size();
            npop = (preq < occ_before) ? preq : occ_before;
            e_unf = (preq > occ_before);
            for (int i = 0; i < npop; i++) begin
                b = sb.pop_front();
                check("sb_pop_byte", (v.gs != 2'd0) ? {24'h0, rx_data[8*i +: 8]} : {24'h0, tx_packet_data},
                      {24'h0, b});
            end
            if (v.gs != 2'd0) begin
                for (int i = occ_before; i < 4; i++) check("sb_zero_lane", {24'h0, rx_data[8*i +: 8]}, 32'h0);
            end
            space = DEPTH - sb.size();
            e_ovf = (wreq > space);
            nw = (wreq < space) ? wreq : space;
            for (int i = 0; i < nw; i++) sb.push_back((v.ps != 2'd0) ? v.td[8*i +: 8] : v.ub);
            e_conf = ((v.ps != 2'd0) && v.up) || ((v.gs != 2'd0) && v.ug);
        end
        @(posedge clk);
        #1;
        check("sb_occupancy", {24'h0, buffer_occupancy}, 32'(sb.size()));
        check("sb_flags", {29'h0, overflow, underflow, conflict}, {29'h0, e_ovf, e_unf, e_conf});
        if (v.chk) begin
            check("tab_occupancy", {24'h0, buffer_occupancy}, {24'h0, v.e_occ});
            check("tab_flags", {29'h0, overflow, underflow, conflict}, {29'h0, v.e_flg});
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t tab [23];

        tab[0]  = mkt(2'd3, 32'hDDCCBBAA, 2'd0, 0, 8'h00, 0, 0, 32'h00000000, 8'h00, 8'd4,  3'b000);
        tab[1]  = mkt(2'd0, 32'h0,        2'd2, 0, 8'h00, 0, 0, 32'hDDCCBBAA, 8'hAA, 8'd2,  3'b000);
        tab[2]  = mkt(2'd0, 32'h0,        2'd0, 0, 8'h00, 0, 0, 32'h0000DDCC, 8'hCC, 8'd2,  3'b000);
        tab[3]  = mkt(2'd0, 32'h0,        2'd2, 0, 8'h00, 0, 0, 32'h0000DDCC, 8'hCC, 8'd0,  3'b000);
        tab[4]  = mkt(2'd0, 32'h0,        2'd0, 1, 8'h11, 0, 0, 32'h00000000, 8'h00, 8'd1,  3'b000);
        tab[5]  = mkt(2'd0, 32'h0,        2'd0, 1, 8'h22, 0, 0, 32'h00000011, 8'h11, 8'd2,  3'b000);
        tab[6]  = mkt(2'd0, 32'h0,        2'd0, 1, 8'h33, 0, 0, 32'h00002211, 8'h11, 8'd3,  3'b000);
        tab[7]  = mkt(2'd0, 32'h0,        2'd0, 0, 8'h00, 1, 0, 32'h00332211, 8'h11, 8'd2,  3'b000);
        tab[8]  = mkt(2'd0, 32'h0,        2'd0, 0, 8'h00, 1, 0, 32'h00003322, 8'h22, 8'd1,  3'b000);
        tab[9]  = mkt(2'd0, 32'h0,        2'd0, 0, 8'h00, 1, 0, 32'h00000033, 8'h33, 8'd0,  3'b000);
        tab[10] = mkt(2'd0, 32'h0,        2'd0, 0, 8'h00, 0, 0, 32'h00000000, 8'h00, 8'd0,  3'b000);
        tab[11] = mkt(2'd2, 32'h1234A1B2, 2'd0, 0, 8'h00, 0, 0, 32'h00000000, 8'h00, 8'd2,  3'b000);
        tab[12] = mkt(2'd1, 32'h000000C3, 2'd1, 1, 8'h77, 1, 0, 32'h0000A1B2, 8'hB2, 8'd2,  3'b001);
        tab[13] = mkt(2'd0, 32'h0,        2'd0, 0, 8'h00, 0, 0, 32'h0000C3A1, 8'hA1, 8'd2,  3'b000);
        tab[14] = mkt(2'd0, 32'h0,        2'd3, 0, 8'h00, 0, 0, 32'h0000C3A1, 8'hA1, 8'd0,  3'b010);
        tab[15] = mkt(2'd0, 32'h0,        2'd0, 1, 8'h5A, 0, 0, 32'h00000000, 8'h00, 8'd1,  3'b000);
        tab[16] = mkt(2'd0, 32'h0,        2'd3, 0, 8'h00, 0, 0, 32'h0000005A, 8'h5A, 8'd0,  3'b010);
        tab[17] = mkt(2'd3, 32'h03020100, 2'd0, 0, 8'h00, 0, 0, 32'h00000000, 8'h00, 8'd4,  3'b000);
        tab[18] = mkt(2'd3, 32'h07060504, 2'd0, 0, 8'h00, 0, 0, 32'h03020100, 8'h00, 8'd8,  3'b000);
        tab[19] = mkt(2'd2, 32'h00000908, 2'd0, 0, 8'h00, 0, 0, 32'h03020100, 8'h00, 8'd10, 3'b000);
        tab[20] = mkt(2'd3, 32'hFFFFFFFF, 2'd0, 0, 8'h00, 0, 1, 32'h03020100, 8'h00, 8'd0,  3'b000);
        tab[21] = mkt(2'd0, 32'h0,        2'd0, 1, 8'hEE, 1, 1, 32'h00000000, 8'h00, 8'd0,  3'b000);
        tab[22] = mkt(2'd0, 32'h0,        2'd0, 0, 8'h00, 0, 0, 32'h00000000, 8'h00, 8'd0,  3'b000);

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_occupancy", {24'h0, buffer_occupancy}, 32'h0);
        check("reset_rx_data", rx_data, 32'h0);
        check("reset_tx_packet_data", {24'h0, tx_packet_data}, 32'h0);
        check("reset_flags", {29'h0, overflow, underflow, conflict}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        for (int k = 0; k < 23; k++) cycle(tab[k]);

        // Fill to capacity, overflow while full, then a pop that frees one byte for a 4B push.
        for (int k = 0; k < DEPTH / 4; k++) begin
            cycle(mkv(2'd3, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, 2'd0, 0, 8'h0, 0, 0));
        end
        check("full_occupancy", {24'h0, buffer_occupancy}, 32'd64);
        cycle(mkv(2'd3, 32'hA3A2A1A0, 2'd0, 0, 8'h0, 0, 0));
        check("full_overflow", {31'h0, overflow}, 32'd1);
        cycle(mkv(2'd0, 32'h0, 2'd1, 0, 8'h0, 0, 0));
        cycle(mkv(2'd3, 32'hB3B2B1B0, 2'd1, 0, 8'h0, 0, 0));
        check("pop_push_full_occupancy", {24'h0, buffer_occupancy}, 32'd64);
        check("pop_push_full_overflow", {31'h0, overflow}, 32'd1);
        for (int k = 0; k < DEPTH / 4; k++) cycle(mkv(2'd0, 32'h0, 2'd3, 0, 8'h0, 0, 0));

        // Walk the pointers to 62 so a 4-byte access straddles the wrap point.
        cycle(mkv(2'd0, 32'h0, 2'd0, 0, 8'h0, 0, 1));
        for (int k = 0; k < 15; k++) begin
            cycle(mkv(2'd3, $urandom, 2'd0, 0, 8'h0, 0, 0));
            cycle(mkv(2'd0, 32'h0, 2'd3, 0, 8'h0, 0, 0));
        end
        cycle(mkv(2'd2, 32'h0000C0DE, 2'd0, 0, 8'h0, 0, 0));
        cycle(mkv(2'd0, 32'h0, 2'd2, 0, 8'h0, 0, 0));
        cycle(mkv(2'd3, 32'h04030201, 2'd0, 0, 8'h0, 0, 0));
        #1;
        check("wrap_rx_data", rx_data, 32'h04030201);
        cycle(mkv(2'd0, 32'h0, 2'd3, 0, 8'h0, 0, 0));
        check("wrap_empty", {24'h0, buffer_occupancy}, 32'h0);

        // Asynchronous reset in the middle of a cycle with data held and a flag high.
        cycle(mkv(2'd3, 32'h44332211, 2'd0, 0, 8'h0, 0, 0));
        cycle(mkv(2'd1, 32'h00000055, 2'd0, 1, 8'h66, 0, 0));
        check("pre_reset_conflict", {31'h0, conflict}, 32'd1);
        store_tx_data = 2'd3; tx_data = 32'h99887766;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_occupancy", {24'h0, buffer_occupancy}, 32'h0);
        check("async_reset_rx_data", rx_data, 32'h0);
        check("async_reset_tx_packet_data", {24'h0, tx_packet_data}, 32'h0);
        check("async_reset_flags", {29'h0, overflow, underflow, conflict}, 32'h0);
        idle_inputs();
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        cycle(mkv(2'd0, 32'h0, 2'd0, 1, 8'h7E, 0, 0));
        cycle(mkv(2'd0, 32'h0, 2'd0, 0, 8'h0, 1, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
